// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types
// Description : Shared types for the LC-3b out-of-order core: the Common Data
//               Bus packet and the default number of result sources.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  localparam int num_cdb_sources = 4;
  localparam int CDB_DATA_WIDTH  = 16;
  localparam int CDB_TAG_WIDTH   = 3;

  // Common Data Bus packet, valid in the LSB
  typedef struct packed {
    logic [CDB_DATA_WIDTH-1:0] data;
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic                      valid;
  } cdb_t;

  // Successor of a round-robin index, wrapping at n
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : lc3b_types
`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first requester
//               at or after the priority pointer, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_vld
);

  // Scan upward from the pointer with wrap-around; first requester wins
  always_comb begin
    int w_j;
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    w_j         = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_grant_vld && i_req[w_j]) begin
        o_grant_vld    = 1'b1;
        o_grant[w_j]   = 1'b1;
        o_grant_idx    = IDX_W'(w_j);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Collects completed results from the functional units into
//               one-entry per-source holding buffers and broadcasts one per
//               cycle, round-robin, on the registered Common Data Bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_SRC = num_cdb_sources
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  cdb_t [NUM_SRC-1:0]   src_in,
  output logic [NUM_SRC-1:0]   src_ack,
  output cdb_t                 CDB_out,
  output logic [NUM_SRC-1:0]   buf_full
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        r_full;
  logic [CDB_DATA_WIDTH-1:0] r_data [NUM_SRC];
  logic [CDB_TAG_WIDTH-1:0]  r_tag  [NUM_SRC];
  logic [IDX_W-1:0]          r_rr_ptr;
  cdb_t                      r_cdb;

  logic [NUM_SRC-1:0]        w_src_vld;
  logic [NUM_SRC-1:0]        w_ack;
  logic [NUM_SRC-1:0]        w_grant_oh;
  logic [IDX_W-1:0]          w_grant_idx;
  logic                      w_grant_vld;

  rr_arbiter #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req       (r_full),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  // A buffer accepts when empty or draining this cycle; reset and flush block
  // acceptance so no station frees itself for a result that will be dropped.
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ack
      assign w_src_vld[i] = src_in[i].valid;
      assign w_ack[i]     = w_src_vld[i] & ~flush & rst_n
                            & (~r_full[i] | w_grant_oh[i]);
    end
  endgenerate

  // Holding buffers, round-robin pointer and registered bus output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= '0;
      r_rr_ptr <= '0;
      r_cdb    <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (flush) begin
      // Discard everything in flight; pointer keeps its fairness position
      r_full      <= '0;
      r_cdb.valid <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_cdb.data <= r_data[w_grant_idx];
        r_cdb.tag  <= r_tag[w_grant_idx];
        r_cdb.valid <= 1'b1;
        r_rr_ptr   <= IDX_W'(rr_next(int'(w_grant_idx), NUM_SRC));
      end else begin
        r_cdb.valid <= 1'b0;
      end
      // A refill in the same cycle as the drain keeps the buffer full
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_ack[i]) begin
          r_full[i] <= 1'b1;
          r_data[i] <= src_in[i].data;
          r_tag[i]  <= src_in[i].tag;
        end else if (w_grant_oh[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  assign src_ack  = w_ack;
  assign CDB_out  = r_cdb;
  assign buf_full = r_full;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter: directed scenarios plus
//               randomized traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  import lc3b_types::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  cdb_t [N-1:0]   src_in;
  logic [N-1:0]   src_ack;
  cdb_t           CDB_out;
  logic [N-1:0]   buf_full;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: holding slots, pointer, expected bus register
  bit          m_full [N];
  logic [15:0] m_data [N];
  logic [2:0]  m_tag  [N];
  int          m_ptr;
  cdb_t        m_cdb;

  cdb_t        obs_cdb;
  logic [N-1:0] obs_ack;
  logic [18:0] bus_log [$];

  cdb_arbiter #(.NUM_SRC(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .src_in   (src_in),
    .src_ack  (src_ack),
    .CDB_out  (CDB_out),
    .buf_full (buf_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_full[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_data[i] = '0; m_tag[i] = '0;
    end
    m_ptr = 0;
    m_cdb = '0;
  endtask

  function automatic logic [N-1:0] m_full_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_full[i];
    return v;
  endfunction

  // One clock: compare at negedge, advance model at posedge, return at posedge+1
  task automatic cycle();
    int g;
    logic [N-1:0] eack;
    @(negedge clk);
    g = m_grant();
    for (int i = 0; i < N; i++)
      eack[i] = src_in[i].valid && !flush && rst_n && (!m_full[i] || g == i);
    check("ack", 32'(src_ack), 32'(eack));
    check("full", 32'(buf_full), 32'(m_full_vec()));
    check("cdb", 32'(CDB_out), 32'(m_cdb));
    obs_cdb = CDB_out;
    obs_ack = src_ack;
    if (CDB_out.valid) bus_log.push_back({CDB_out.data, CDB_out.tag});
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_cdb.valid = 1'b0;
    end else begin
      if (g >= 0) begin
        m_cdb = '{data: m_data[g], tag: m_tag[g], valid: 1'b1};
        m_full[g] = 0;
        m_ptr = (g + 1) % N;
      end else begin
        m_cdb.valid = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (eack[i]) begin
          m_full[i] = 1; m_data[i] = src_in[i].data; m_tag[i] = src_in[i].tag;
        end
    end
    #1;
  endtask

  task automatic idle(input int n);
    src_in = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Asynchronous reset pulse between clock edges with inputs left asserted
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check("rst_full", 32'(buf_full), 32'h0);
    check("rst_cdb", 32'(CDB_out), 32'h0);
    check("rst_ack", 32'(src_ack), 32'h0);
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drive(input int i, input logic [15:0] d, input logic [2:0] t);
    src_in[i] = '{data: d, tag: t, valid: 1'b1};
  endtask

  initial begin
    int waits;
    src_in = '0;
    for (int i = 0; i < N; i++) src_in[i].valid = 1'b1;
    model_reset();
    #12;
    check("reset_full", 32'(buf_full), 32'h0);
    check("reset_cdb", 32'(CDB_out), 32'h0);
    check("reset_ack", 32'(src_ack), 32'h0);
    src_in = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single result: ack same cycle, on the bus two cycles later
    drive(1, 16'h1234, 3'd5);
    cycle();
    check("single_ack", 32'(obs_ack), 32'h2);
    src_in = '0;
    cycle();
    check("single_t1", 32'(obs_cdb.valid), 32'h0);
    cycle();
    check("single_t2", 32'(obs_cdb), 32'({16'h1234, 3'd5, 1'b1}));
    cycle();
    check("single_t3", 32'(obs_cdb.valid), 32'h0);

    // Fairness: pointer now 2, so source 3 precedes source 0
    bus_log.delete();
    drive(0, 16'hF000, 3'd6);
    drive(3, 16'hF003, 3'd7);
    cycle();
    idle(4);
    check("fair_n", 32'(bus_log.size()), 32'd2);
    if (bus_log.size() == 2) begin
      check("fair_0", 32'(bus_log[0]), 32'({16'hF003, 3'd7}));
      check("fair_1", 32'(bus_log[1]), 32'({16'hF000, 3'd6}));
    end

    // Contention from pointer 0: tags 0..3 in order
    async_reset();
    bus_log.delete();
    for (int i = 0; i < N; i++) drive(i, 16'hA000 + 16'(i), 3'(i));
    cycle();
    check("cont_ack", 32'(obs_ack), 32'hF);
    idle(6);
    check("cont_n", 32'(bus_log.size()), 32'd4);
    for (int i = 0; i < N && i < bus_log.size(); i++)
      check("cont_ord", 32'(bus_log[i]), 32'({16'hA000 + 16'(i), 3'(i)}));

    // Back-to-back from one source
    bus_log.delete();
    for (int k = 1; k <= 3; k++) begin
      drive(2, 16'(k), 3'd2);
      cycle();
      check("b2b_ack", 32'(obs_ack), 32'h4);
    end
    idle(4);
    check("b2b_n", 32'(bus_log.size()), 32'd3);
    for (int k = 0; k < 3 && k < bus_log.size(); k++)
      check("b2b_data", 32'(bus_log[k]), 32'({16'(k + 1), 3'd2}));

    // Blocked buffer: move pointer to 1, then source 1 wins over full source 0
    drive(0, 16'h0100, 3'd0);
    cycle();
    idle(3);
    bus_log.delete();
    drive(0, 16'h0AAA, 3'd1);
    drive(1, 16'h0BBB, 3'd2);
    cycle();
    src_in = '0;
    drive(0, 16'h0CCC, 3'd3);
    waits = 0;
    obs_ack = '0;
    while (!obs_ack[0] && waits < 8) begin
      cycle();
      waits++;
    end
    check("blk_wait", 32'(waits), 32'd2);
    idle(5);
    check("blk_n", 32'(bus_log.size()), 32'd3);
    if (bus_log.size() == 3) begin
      check("blk_0", 32'(bus_log[0]), 32'({16'h0BBB, 3'd2}));
      check("blk_1", 32'(bus_log[1]), 32'({16'h0AAA, 3'd1}));
      check("blk_2", 32'(bus_log[2]), 32'({16'h0CCC, 3'd3}));
    end

    // Flush with three buffers full and every source requesting
    for (int i = 0; i < 3; i++) drive(i, 16'h5000 + 16'(i), 3'(i));
    cycle();
    for (int i = 0; i < N; i++) drive(i, 16'h6000, 3'd4);
    flush = 1'b1;
    cycle();
    check("flush_ack", 32'(obs_ack), 32'h0);
    flush = 1'b0;
    src_in = '0;
    cycle();
    check("flush_full", 32'(buf_full), 32'h0);
    check("flush_vld", 32'(obs_cdb.valid), 32'h0);

    // Reset mid-operation with buffers full
    for (int i = 1; i < N; i++) drive(i, 16'h7000 + 16'(i), 3'(i));
    cycle();
    async_reset();
    idle(2);

    // Randomized traffic, with occasional flush and reset
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        src_in[i].valid = 1'($urandom_range(0, 1));
        src_in[i].data  = 16'($urandom);
        src_in[i].tag   = 3'($urandom);
      end
      flush = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) async_reset();
      cycle();
    end
    flush = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_cdb_arbiter
`default_nettype wire
